// File: rtl/cv32e41s_pkg.sv
// Shared types and constants for the fence.i sequencer slice.
//   fencei_seq_state_e : sequencer FSM state encoding
//   FENCEI_DRAIN_CNT_W : width of the LSU idle-window counter
package cv32e41s_pkg;

  localparam int unsigned FENCEI_DRAIN_CNT_W = 4;

  typedef enum logic [1:0] {
    FENCEI_IDLE,
    FENCEI_DRAIN,
    FENCEI_REQ,
    FENCEI_DONE
  } fencei_seq_state_e;

endpackage

// File: rtl/cv32e41s_fencei_drain_cnt.sv
// Saturating idle-window counter.
// Counts consecutive idle cycles and reports when the current idle cycle
// completes a window of HOLD cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : hold the counter at zero (not in the window phase)
//   idle       : the monitored resource is idle this cycle
//   hit_c      : combinational, this idle cycle is the HOLD-th in a row
module cv32e41s_fencei_drain_cnt
  import cv32e41s_pkg::*;
#(
  parameter int unsigned HOLD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic idle,
  output logic hit_c
);

  localparam int unsigned W       = FENCEI_DRAIN_CNT_W;
  localparam int unsigned CW      = W + 1;
  localparam int unsigned CNT_MAX = (1 << W) - 1;

  logic [W-1:0]  count_q;
  logic [W-1:0]  count_d;
  logic [CW-1:0] count_inc;

  // Next count: any non-idle cycle restarts the window; saturate at the top.
  always_comb begin
    count_inc = {1'b0, count_q} + CW'(1);
    count_d   = count_q;
    if (clr || !idle) begin
      count_d = '0;
    end else if (count_q != W'(CNT_MAX)) begin
      count_d = count_inc[W-1:0];
    end
  end

  // Window completes on the cycle the count reaches HOLD.
  assign hit_c = !clr && idle && (count_inc >= CW'(HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cv32e41s_fencei_sequencer.sv
// fence.i flush sequencer for the controller FSM.
// On a fence.i in WB: halt the pipe, wait for the LSU and write buffer to
// stay idle for DRAIN_HOLD cycles, run the flush req/ack handshake, then
// pulse done for one cycle.
// Optional feature macro: CV32E41S_FENCEI_TIMEOUT_EN enables a sticky
// timeout flag when the ack takes ACK_TIMEOUT REQ cycles or more.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   fencei_start_i      : fence.i in WB, start the sequence (IDLE only)
//   abort_i             : kill the sequence while draining
//   lsu_busy_i          : LSU has outstanding transfers
//   wbuf_empty_i        : LSU write buffer empty
//   fencei_flush_req_o  : flush request to the external side
//   fencei_flush_ack_i  : flush acknowledge from the external side
//   halt_pipe_o         : halt IF/ID/EX
//   busy_o              : sequencer not idle
//   done_o              : one-cycle completion pulse
//   timeout_o           : sticky ack timeout flag (0 when feature disabled)
module cv32e41s_fencei_sequencer
  import cv32e41s_pkg::*;
#(
  parameter int unsigned DRAIN_HOLD  = 1,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fencei_start_i,
  input  logic abort_i,
  input  logic lsu_busy_i,
  input  logic wbuf_empty_i,
  output logic fencei_flush_req_o,
  input  logic fencei_flush_ack_i,
  output logic halt_pipe_o,
  output logic busy_o,
  output logic done_o,
  output logic timeout_o
);

  fencei_seq_state_e state_q;
  fencei_seq_state_e state_d;

  logic lsu_idle_c;
  logic drain_clr_c;
  logic drain_hit_c;

  logic req_d;
  logic halt_d;
  logic busy_d;
  logic done_d;

  assign lsu_idle_c  = !lsu_busy_i && wbuf_empty_i;
  assign drain_clr_c = (state_q != FENCEI_DRAIN);

  cv32e41s_fencei_drain_cnt #(
    .HOLD (DRAIN_HOLD)
  ) u_drain_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (drain_clr_c),
    .idle  (lsu_idle_c),
    .hit_c (drain_hit_c)
  );

  // Next state and next-cycle outputs.
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    halt_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      FENCEI_IDLE: begin
        // Start wins over a concurrent abort; ack is ignored here.
        if (fencei_start_i) begin
          state_d = FENCEI_DRAIN;
        end
      end
      FENCEI_DRAIN: begin
        // Abort wins over a drain window completing in the same cycle.
        if (abort_i) begin
          state_d = FENCEI_IDLE;
        end else if (drain_hit_c) begin
          state_d = FENCEI_REQ;
        end
      end
      FENCEI_REQ: begin
        // Handshake cannot be abandoned once the request is out.
        if (fencei_flush_ack_i) begin
          state_d = FENCEI_DONE;
        end
      end
      FENCEI_DONE: begin
        state_d = FENCEI_IDLE;
      end
      default: begin
        state_d = FENCEI_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with it.
    req_d  = (state_d == FENCEI_REQ);
    done_d = (state_d == FENCEI_DONE);
    halt_d = (state_d != FENCEI_IDLE);
    busy_d = (state_d != FENCEI_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= FENCEI_IDLE;
      fencei_flush_req_o <= 1'b0;
      halt_pipe_o        <= 1'b0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
    end else begin
      state_q            <= state_d;
      fencei_flush_req_o <= req_d;
      halt_pipe_o        <= halt_d;
      busy_o             <= busy_d;
      done_o             <= done_d;
    end
  end

`ifdef CV32E41S_FENCEI_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;
  logic            timeout_d;

  // Counter sits at zero outside REQ, so every REQ visit starts from zero.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_o;
    if ((state_q == FENCEI_IDLE) && fencei_start_i) begin
      timeout_d = 1'b0;
    end
    if (state_q != FENCEI_REQ) begin
      to_cnt_d = '0;
    end else if (!fencei_flush_ack_i && (to_cnt_q != TO_W'(ACK_TIMEOUT))) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      if (to_cnt_d == TO_W'(ACK_TIMEOUT)) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      timeout_o <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_o <= timeout_d;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

  // Parameter legality.
  a_param_range : assert property (@(posedge clk)
    (DRAIN_HOLD inside {[1:15]}) && (ACK_TIMEOUT inside {[2:65535]}));

  // A new fence.i may only arrive while the sequencer is idle.
  a_start_idle : assert property (@(posedge clk) disable iff (!rst_n)
    fencei_start_i |-> (state_q == FENCEI_IDLE));

endmodule

// File: tb/tb_cv32e41s_fencei_sequencer.sv
// Bench for cv32e41s_fencei_sequencer: two instances (DRAIN_HOLD=1 and 3)
// share stimulus; each scenario queues expected output vectors
// {req, halt, busy, done, timeout} per cycle and compares them after the edge.
module tb_cv32e41s_fencei_sequencer;

  localparam logic [4:0] IDLE  = 5'b00000;
  localparam logic [4:0] DRAIN = 5'b01100;
  localparam logic [4:0] REQ   = 5'b11100;
  localparam logic [4:0] DONE  = 5'b01110;
`ifdef CV32E41S_FENCEI_TIMEOUT_EN
  localparam logic [4:0] TO    = 5'b00001;
`else
  localparam logic [4:0] TO    = 5'b00000;
`endif

  typedef struct packed {
    logic       start;
    logic       abort;
    logic       lbusy;
    logic       wempty;
    logic       ack;
    logic [4:0] e1;
    logic [4:0] e3;
  } step_t;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic lbusy;
  logic wempty;
  logic ack;

  logic req1, halt1, busy1, done1, to1;
  logic req3, halt3, busy3, done3, to3;
  logic [4:0] o1;
  logic [4:0] o3;

  assign o1 = {req1, halt1, busy1, done1, to1};
  assign o3 = {req3, halt3, busy3, done3, to3};

  int    errors = 0;
  int    checks = 0;
  int    cyc;
  step_t steps[$];
  step_t exp_q[$];
  step_t st;
  step_t ex;

  cv32e41s_fencei_sequencer #(.DRAIN_HOLD(1), .ACK_TIMEOUT(16)) u_dut1 (
    .clk                (clk),
    .rst_n              (rst_n),
    .fencei_start_i     (start),
    .abort_i            (abort),
    .lsu_busy_i         (lbusy),
    .wbuf_empty_i       (wempty),
    .fencei_flush_req_o (req1),
    .fencei_flush_ack_i (ack),
    .halt_pipe_o        (halt1),
    .busy_o             (busy1),
    .done_o             (done1),
    .timeout_o          (to1)
  );

  cv32e41s_fencei_sequencer #(.DRAIN_HOLD(3), .ACK_TIMEOUT(16)) u_dut3 (
    .clk                (clk),
    .rst_n              (rst_n),
    .fencei_start_i     (start),
    .abort_i            (abort),
    .lsu_busy_i         (lbusy),
    .wbuf_empty_i       (wempty),
    .fencei_flush_req_o (req3),
    .fencei_flush_ack_i (ack),
    .halt_pipe_o        (halt3),
    .busy_o             (busy3),
    .done_o             (done3),
    .timeout_o          (to3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic step_t mk(input logic s, input logic a, input logic lb,
                               input logic we, input logic k,
                               input logic [4:0] e1, input logic [4:0] e3);
    step_t r;
    r.start = s; r.abort = a; r.lbusy = lb; r.wempty = we; r.ack = k;
    r.e1 = e1; r.e3 = e3;
    return r;
  endfunction

  task automatic drive(input step_t s);
    start  = s.start;
    abort  = s.abort;
    lbusy  = s.lbusy;
    wempty = s.wempty;
    ack    = s.ack;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 1, 0, IDLE, IDLE));
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o1 !== IDLE) begin errors++; $display("FAIL reset_hold dut1: got %b want %b", o1, IDLE); end
    checks++;
    if (o3 !== IDLE) begin errors++; $display("FAIL reset_hold dut3: got %b want %b", o3, IDLE); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (o1 !== IDLE) begin errors++; $display("FAIL reset_release dut1: got %b want %b", o1, IDLE); end
    checks++;
    if (o3 !== IDLE) begin errors++; $display("FAIL reset_release dut3: got %b want %b", o3, IDLE); end
  endtask

  task automatic test_latency;
    steps.push_back(mk(1, 0, 0, 1, 1, DRAIN, DRAIN));
    steps.push_back(mk(0, 0, 0, 1, 1, REQ,   DRAIN));
    steps.push_back(mk(0, 0, 0, 1, 1, DONE,  DRAIN));
    steps.push_back(mk(0, 0, 0, 1, 1, IDLE,  REQ));
    steps.push_back(mk(0, 0, 0, 1, 1, IDLE,  DONE));
    steps.push_back(mk(0, 0, 0, 1, 1, IDLE,  IDLE));
    cyc = 0;
    while (steps.size() > 0) begin
      st = steps.pop_front();
      drive(st);
      exp_q.push_back(st);
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      cyc++;
      checks++;
      if (o1 !== ex.e1) begin errors++; $display("FAIL latency dut1 c%0d: got %b want %b", cyc, o1, ex.e1); end
      checks++;
      if (o3 !== ex.e3) begin errors++; $display("FAIL latency dut3 c%0d: got %b want %b", cyc, o3, ex.e3); end
    end
  endtask

  task automatic test_drain_window;
    logic [4:0] e1;
    logic [4:0] e3;
    // LSU busy in cycles 1..5, idle from cycle 6.
    for (int i = 0; i <= 10; i++) begin
      e1 = (i <= 5) ? DRAIN : (i == 6) ? REQ : (i == 7) ? DONE : IDLE;
      e3 = (i <= 7) ? DRAIN : (i == 8) ? REQ : (i == 9) ? DONE : IDLE;
      steps.push_back(mk(i == 0, 0, (i >= 1) && (i <= 5), 1, 1, e1, e3));
    end
    // Write buffer not empty in cycle 2 restarts the window.
    for (int i = 0; i <= 7; i++) begin
      e1 = (i == 0) ? DRAIN : (i == 1) ? REQ : (i == 2) ? DONE : IDLE;
      e3 = (i <= 4) ? DRAIN : (i == 5) ? REQ : (i == 6) ? DONE : IDLE;
      steps.push_back(mk(i == 0, 0, 0, i != 2, 1, e1, e3));
    end
    cyc = 0;
    while (steps.size() > 0) begin
      st = steps.pop_front();
      drive(st);
      exp_q.push_back(st);
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      cyc++;
      checks++;
      if (o1 !== ex.e1) begin errors++; $display("FAIL drain_window dut1 c%0d: got %b want %b", cyc, o1, ex.e1); end
      checks++;
      if (o3 !== ex.e3) begin errors++; $display("FAIL drain_window dut3 c%0d: got %b want %b", cyc, o3, ex.e3); end
    end
  endtask

  task automatic test_ack_delay;
    logic [4:0] e1;
    logic [4:0] e3;
    for (int i = 0; i <= 10; i++) begin
      e1 = (i == 0) ? DRAIN : (i <= 8) ? REQ : (i == 9) ? DONE : IDLE;
      e3 = (i <= 2) ? DRAIN : (i <= 8) ? REQ : (i == 9) ? DONE : IDLE;
      steps.push_back(mk(i == 0, 0, 0, 1, i == 9, e1, e3));
    end
    cyc = 0;
    while (steps.size() > 0) begin
      st = steps.pop_front();
      drive(st);
      exp_q.push_back(st);
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      cyc++;
      checks++;
      if (o1 !== ex.e1) begin errors++; $display("FAIL ack_delay dut1 c%0d: got %b want %b", cyc, o1, ex.e1); end
      checks++;
      if (o3 !== ex.e3) begin errors++; $display("FAIL ack_delay dut3 c%0d: got %b want %b", cyc, o3, ex.e3); end
    end
  endtask

  task automatic test_abort;
    // Abort in DRAIN, coinciding with dut1's window completing.
    steps.push_back(mk(1, 0, 0, 1, 1, DRAIN, DRAIN));
    steps.push_back(mk(0, 0, 1, 1, 1, DRAIN, DRAIN));
    steps.push_back(mk(0, 1, 0, 1, 1, IDLE,  IDLE));
    steps.push_back(mk(0, 0, 0, 1, 1, IDLE,  IDLE));
    steps.push_back(mk(0, 0, 0, 1, 1, IDLE,  IDLE));
    // Abort together with start in IDLE: start wins.
    steps.push_back(mk(1, 1, 0, 1, 1, DRAIN, DRAIN));
    steps.push_back(mk(0, 0, 0, 1, 1, REQ,   DRAIN));
    steps.push_back(mk(0, 0, 0, 1, 1, DONE,  DRAIN));
    steps.push_back(mk(0, 0, 0, 1, 1, IDLE,  REQ));
    steps.push_back(mk(0, 0, 0, 1, 1, IDLE,  DONE));
    steps.push_back(mk(0, 0, 0, 1, 1, IDLE,  IDLE));
    // Abort in REQ is ignored by dut1, kills dut3 still draining.
    steps.push_back(mk(1, 0, 0, 1, 0, DRAIN, DRAIN));
    steps.push_back(mk(0, 0, 0, 1, 0, REQ,   DRAIN));
    steps.push_back(mk(0, 1, 0, 1, 0, REQ,   IDLE));
    steps.push_back(mk(0, 0, 0, 1, 1, DONE,  IDLE));
    steps.push_back(mk(0, 0, 0, 1, 0, IDLE,  IDLE));
    cyc = 0;
    while (steps.size() > 0) begin
      st = steps.pop_front();
      drive(st);
      exp_q.push_back(st);
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      cyc++;
      checks++;
      if (o1 !== ex.e1) begin errors++; $display("FAIL abort dut1 c%0d: got %b want %b", cyc, o1, ex.e1); end
      checks++;
      if (o3 !== ex.e3) begin errors++; $display("FAIL abort dut3 c%0d: got %b want %b", cyc, o3, ex.e3); end
    end
  endtask

  task automatic test_timeout;
    logic [4:0] e1;
    logic [4:0] e3;
    for (int i = 0; i <= 28; i++) begin
      if (i == 0)       e1 = DRAIN;
      else if (i <= 19) e1 = REQ | ((i >= 17) ? TO : 5'b0);
      else if (i == 20) e1 = DONE | TO;
      else if (i <= 22) e1 = IDLE | TO;
      else if (i == 23) e1 = DRAIN;
      else if (i == 24) e1 = REQ;
      else if (i == 25) e1 = DONE;
      else              e1 = IDLE;
      if (i <= 2)       e3 = DRAIN;
      else if (i <= 19) e3 = REQ | ((i >= 19) ? TO : 5'b0);
      else if (i == 20) e3 = DONE | TO;
      else if (i <= 22) e3 = IDLE | TO;
      else if (i <= 25) e3 = DRAIN;
      else if (i == 26) e3 = REQ;
      else if (i == 27) e3 = DONE;
      else              e3 = IDLE;
      steps.push_back(mk((i == 0) || (i == 23), 0, 0, 1, (i == 20) || (i >= 24), e1, e3));
    end
    cyc = 0;
    while (steps.size() > 0) begin
      st = steps.pop_front();
      drive(st);
      exp_q.push_back(st);
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      cyc++;
      checks++;
      if (o1 !== ex.e1) begin errors++; $display("FAIL timeout dut1 c%0d: got %b want %b", cyc, o1, ex.e1); end
      checks++;
      if (o3 !== ex.e3) begin errors++; $display("FAIL timeout dut3 c%0d: got %b want %b", cyc, o3, ex.e3); end
    end
  endtask

  task automatic test_reset_in_req;
    steps.push_back(mk(1, 0, 0, 1, 0, DRAIN, DRAIN));
    steps.push_back(mk(0, 0, 0, 1, 0, REQ,   DRAIN));
    cyc = 0;
    while (steps.size() > 0) begin
      st = steps.pop_front();
      drive(st);
      exp_q.push_back(st);
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      cyc++;
      checks++;
      if (o1 !== ex.e1) begin errors++; $display("FAIL reset_req_pre dut1 c%0d: got %b want %b", cyc, o1, ex.e1); end
      checks++;
      if (o3 !== ex.e3) begin errors++; $display("FAIL reset_req_pre dut3 c%0d: got %b want %b", cyc, o3, ex.e3); end
    end
    // Assert reset between clock edges; outputs must drop without an edge.
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o1 !== IDLE) begin errors++; $display("FAIL reset_req_async dut1: got %b want %b", o1, IDLE); end
    checks++;
    if (o3 !== IDLE) begin errors++; $display("FAIL reset_req_async dut3: got %b want %b", o3, IDLE); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // An ack pulse in IDLE after reset must produce nothing.
    steps.push_back(mk(0, 0, 0, 1, 1, IDLE, IDLE));
    steps.push_back(mk(0, 0, 0, 1, 0, IDLE, IDLE));
    steps.push_back(mk(0, 0, 0, 1, 0, IDLE, IDLE));
    cyc = 0;
    while (steps.size() > 0) begin
      st = steps.pop_front();
      drive(st);
      exp_q.push_back(st);
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      cyc++;
      checks++;
      if (o1 !== ex.e1) begin errors++; $display("FAIL reset_req_post dut1 c%0d: got %b want %b", cyc, o1, ex.e1); end
      checks++;
      if (o3 !== ex.e3) begin errors++; $display("FAIL reset_req_post dut3 c%0d: got %b want %b", cyc, o3, ex.e3); end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    lbusy  = 1'b0;
    wempty = 1'b1;
    ack    = 1'b0;
    #1;
    test_reset();
    test_latency();
    test_drain_window();
    test_ack_delay();
    test_abort();
    test_timeout();
    test_reset_in_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
